// File: rtl/output_layer_accumulator.sv
// Output-layer score generator: ten parallel signed MACs over N_IN activation beats,
// then per-class saturation to OUT_W bits with a one-cycle out_valid pulse.
module output_layer_accumulator #(
  parameter int N_IN  = 100,
  parameter int ACT_W = 16,
  parameter int W_W   = 8,
  parameter int ACC_W = 32,
  parameter int OUT_W = 26
) (
  input  logic                    clk,
  input  logic                    GlobalReset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACT_W-1:0] act,
  input  logic signed [W_W-1:0]   w_0,
  input  logic signed [W_W-1:0]   w_1,
  input  logic signed [W_W-1:0]   w_2,
  input  logic signed [W_W-1:0]   w_3,
  input  logic signed [W_W-1:0]   w_4,
  input  logic signed [W_W-1:0]   w_5,
  input  logic signed [W_W-1:0]   w_6,
  input  logic signed [W_W-1:0]   w_7,
  input  logic signed [W_W-1:0]   w_8,
  input  logic signed [W_W-1:0]   w_9,
  output logic                    busy,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        Out_0,
  output logic [OUT_W-1:0]        Out_1,
  output logic [OUT_W-1:0]        Out_2,
  output logic [OUT_W-1:0]        Out_3,
  output logic [OUT_W-1:0]        Out_4,
  output logic [OUT_W-1:0]        Out_5,
  output logic [OUT_W-1:0]        Out_6,
  output logic [OUT_W-1:0]        Out_7,
  output logic [OUT_W-1:0]        Out_8,
  output logic [OUT_W-1:0]        Out_9
);

  localparam int N_CLS  = 10;
  localparam int CNT_W  = $clog2(N_IN + 1);
  localparam int PROD_W = ACT_W + W_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                   state, next_state;
  logic [CNT_W-1:0]         count;
  logic signed [ACC_W-1:0]  acc   [N_CLS];
  logic signed [W_W-1:0]    w     [N_CLS];
  logic signed [PROD_W-1:0] prod  [N_CLS];
  logic [OUT_W-1:0]         out_r [N_CLS];
  logic                     clear_acc, accept, load_out;

  assign w[0] = w_0;
  assign w[1] = w_1;
  assign w[2] = w_2;
  assign w[3] = w_3;
  assign w[4] = w_4;
  assign w[5] = w_5;
  assign w[6] = w_6;
  assign w[7] = w_7;
  assign w[8] = w_8;
  assign w[9] = w_9;

  assign Out_0 = out_r[0];
  assign Out_1 = out_r[1];
  assign Out_2 = out_r[2];
  assign Out_3 = out_r[3];
  assign Out_4 = out_r[4];
  assign Out_5 = out_r[5];
  assign Out_6 = out_r[6];
  assign Out_7 = out_r[7];
  assign Out_8 = out_r[8];
  assign Out_9 = out_r[9];

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);

  // Clamp to OUT_W: in range iff every bit from OUT_W-1 upward matches the sign.
  function automatic logic [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-OUT_W:0] top;
    top = a[ACC_W-1:OUT_W-1];
    if ((&top) || (~|top))
      return a[OUT_W-1:0];
    else if (a[ACC_W-1])
      return {1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // A start in ACCUM wins over a simultaneous beat, which is dropped.
  always_comb begin
    next_state = state;
    clear_acc  = 1'b0;
    accept     = 1'b0;
    load_out   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear_acc  = 1'b1;
          next_state = ACCUM;
        end
      end
      ACCUM: begin
        if (start) begin
          clear_acc = 1'b1;
        end else if (in_valid) begin
          accept = 1'b1;
          if (count == CNT_W'(N_IN - 1))
            next_state = DONE;
        end
      end
      DONE: begin
        load_out   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < N_CLS; k++)
      prod[k] = PROD_W'(act) * PROD_W'(w[k]);
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      count     <= '0;
      out_valid <= 1'b0;
      for (int k = 0; k < N_CLS; k++) begin
        acc[k]   <= '0;
        out_r[k] <= '0;
      end
    end else begin
      out_valid <= load_out;
      if (clear_acc) begin
        count <= '0;
        for (int k = 0; k < N_CLS; k++)
          acc[k] <= '0;
      end else if (accept) begin
        count <= count + 1'b1;
        for (int k = 0; k < N_CLS; k++)
          acc[k] <= acc[k] + ACC_W'(prod[k]);
      end
      if (load_out) begin
        for (int k = 0; k < N_CLS; k++)
          out_r[k] <= saturate(acc[k]);
      end
    end
  end

endmodule

// File: tb/tb_output_layer_accumulator.sv
// Directed bench for output_layer_accumulator: reset, basic MAC, signs with gaps,
// saturation, restart and idle/overlap behaviour against hand-computed scores.
module tb_output_layer_accumulator;

  logic               clk = 1'b0;
  logic               GlobalReset;
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] act;
  logic signed [7:0]  w [10];
  logic               busy;
  logic               out_valid;
  logic [25:0]        out_s [10];

  int checks   = 0;
  int failures = 0;
  int early_valid;

  output_layer_accumulator dut (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .act        (act),
    .w_0        (w[0]),
    .w_1        (w[1]),
    .w_2        (w[2]),
    .w_3        (w[3]),
    .w_4        (w[4]),
    .w_5        (w[5]),
    .w_6        (w[6]),
    .w_7        (w[7]),
    .w_8        (w[8]),
    .w_9        (w[9]),
    .busy       (busy),
    .out_valid  (out_valid),
    .Out_0      (out_s[0]),
    .Out_1      (out_s[1]),
    .Out_2      (out_s[2]),
    .Out_3      (out_s[3]),
    .Out_4      (out_s[4]),
    .Out_5      (out_s[5]),
    .Out_6      (out_s[6]),
    .Out_7      (out_s[7]),
    .Out_8      (out_s[8]),
    .Out_9      (out_s[9])
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic signed [15:0] a);
    start    = s;
    in_valid = v;
    act      = a;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic clear_weights();
    for (int k = 0; k < 10; k++)
      w[k] = 8'sd0;
  endtask

  task automatic pulse_start();
    applyStimulus(1'b1, 1'b0, act);
    step();
    applyStimulus(1'b0, 1'b0, act);
  endtask

  task automatic run_beats(input int n, input logic signed [15:0] a);
    applyStimulus(1'b0, 1'b1, a);
    repeat (n) step();
    applyStimulus(1'b0, 1'b0, a);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 16'sd0);
    clear_weights();
    GlobalReset = 1'b0;
    repeat (3) step();
    GlobalReset = 1'b1;
    step();
    $display("[TB] reset state");
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd0);
    checkOutput("rst_busy",      {31'd0, busy},      32'd0);
    checkOutput("rst_out_0",     {6'd0, out_s[0]},   32'd0);

    $display("[TB] basic act=1 w_k=k");
    for (int k = 0; k < 10; k++)
      w[k] = 8'(k);
    pulse_start();
    checkOutput("basic_in_ready", {31'd0, in_ready}, 32'd1);
    run_beats(100, 16'sd1);
    checkOutput("basic_done_valid",    {31'd0, out_valid}, 32'd0);
    checkOutput("basic_done_in_ready", {31'd0, in_ready},  32'd0);
    checkOutput("basic_done_busy",     {31'd0, busy},      32'd1);
    step();
    checkOutput("basic_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("basic_out_0", {6'd0, out_s[0]}, 32'd0);
    checkOutput("basic_out_1", {6'd0, out_s[1]}, 32'd100);
    checkOutput("basic_out_5", {6'd0, out_s[5]}, 32'd500);
    checkOutput("basic_out_9", {6'd0, out_s[9]}, 32'd900);
    checkOutput("basic_idle_busy", {31'd0, busy}, 32'd0);
    step();
    checkOutput("basic_valid_pulse", {31'd0, out_valid}, 32'd0);
    checkOutput("basic_hold_9", {6'd0, out_s[9]}, 32'd900);

    $display("[TB] asynchronous reset mid-inference");
    pulse_start();
    run_beats(40, 16'sd1);
    #2;
    GlobalReset = 1'b0;
    #1;
    checkOutput("arst_out_9",     {6'd0, out_s[9]},   32'd0);
    checkOutput("arst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst_in_ready",  {31'd0, in_ready},  32'd0);
    checkOutput("arst_busy",      {31'd0, busy},      32'd0);
    @(negedge clk);
    GlobalReset = 1'b1;
    step();
    for (int k = 0; k < 10; k++)
      w[k] = 8'sd1;
    pulse_start();
    run_beats(100, 16'sd2);
    step();
    checkOutput("arst_fresh_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("arst_fresh_0", {6'd0, out_s[0]}, 32'd200);
    checkOutput("arst_fresh_9", {6'd0, out_s[9]}, 32'd200);

    $display("[TB] signed weights with gaps");
    clear_weights();
    w[2] = -8'sd5;
    pulse_start();
    early_valid = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b1, 16'sd3);
      step();
      applyStimulus(1'b0, 1'b0, 16'sd3);
      if (out_valid) early_valid++;
      if (i < 99) begin
        step();
        if (out_valid) early_valid++;
      end
    end
    checkOutput("gap_no_early_valid", early_valid, 32'd0);
    step();
    checkOutput("gap_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("gap_out_2", {6'd0, out_s[2]}, 32'h03FFFA24);
    checkOutput("gap_out_0", {6'd0, out_s[0]}, 32'd0);

    $display("[TB] saturation");
    clear_weights();
    w[0] = 8'sd127;
    w[1] = -8'sd128;
    pulse_start();
    run_beats(100, 16'sd32767);
    step();
    checkOutput("sat_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("sat_pos",   {6'd0, out_s[0]}, 32'h01FFFFFF);
    checkOutput("sat_neg",   {6'd0, out_s[1]}, 32'h02000000);
    checkOutput("sat_zero2", {6'd0, out_s[2]}, 32'd0);
    checkOutput("sat_zero9", {6'd0, out_s[9]}, 32'd0);

    $display("[TB] restart during accumulation");
    clear_weights();
    w[0] = 8'sd1;
    pulse_start();
    run_beats(40, 16'sd5);
    applyStimulus(1'b1, 1'b1, 16'sd5);
    step();
    checkOutput("restart_busy", {31'd0, busy}, 32'd1);
    run_beats(100, 16'sd1);
    step();
    checkOutput("restart_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("restart_out_0", {6'd0, out_s[0]}, 32'd100);

    $display("[TB] idle beats and start overlapping out_valid");
    applyStimulus(1'b0, 1'b1, 16'sd7);
    repeat (3) step();
    checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("idle_busy",     {31'd0, busy},     32'd0);
    checkOutput("idle_hold_0",   {6'd0, out_s[0]},  32'd100);
    applyStimulus(1'b0, 1'b0, 16'sd0);
    pulse_start();
    run_beats(100, 16'sd2);
    step();
    checkOutput("ovl_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("ovl_out_0", {6'd0, out_s[0]}, 32'd200);
    w[0] = 8'sd3;
    pulse_start();
    checkOutput("ovl_busy",        {31'd0, busy},      32'd1);
    checkOutput("ovl_valid_clear", {31'd0, out_valid}, 32'd0);
    checkOutput("ovl_hold_0",      {6'd0, out_s[0]},   32'd200);
    run_beats(100, 16'sd1);
    checkOutput("ovl_done_hold_0", {6'd0, out_s[0]}, 32'd200);
    step();
    checkOutput("ovl_new_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("ovl_new_out_0", {6'd0, out_s[0]}, 32'd300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_layer_accumulator.md
Name: output_layer_accumulator

Overview:
Output-layer score generator for the classifier datapath. It streams N_IN hidden-layer activations, each paired with one weight per class, and runs ten parallel signed multiply-accumulates. It then saturates the ten class scores to 26-bit two's complement and presents them on Out_0..Out_9 with a one-cycle out_valid pulse. The max-selector consumes these scores and resolves the class index.

Parameters:
N_IN, 100, activation/weight beats per inference
ACT_W, 16, signed activation width
W_W, 8, signed weight width
ACC_W, 32, internal accumulator width; must be >= ACT_W+W_W+clog2(N_IN)
OUT_W, 26, signed score width presented downstream

Ports:
clk  input  1  clock, all state on rising edge
GlobalReset  input  1  asynchronous active-low reset
start  input  1  pulse: clear accumulators, begin an inference
in_valid  input  1  act/w_k beat valid
in_ready  output  1  block accepts a beat this cycle
act  input  ACT_W  signed hidden activation
w_0 .. w_9  input  W_W each  signed weight of current activation toward class k
busy  output  1  high in ACCUM and DONE
out_valid  output  1  one-cycle pulse: Out_0..Out_9 hold a new result
Out_0 .. Out_9  output  OUT_W each  signed saturated class scores, registered

Behaviour:
- Reset (GlobalReset=0, asynchronous) forces:
  - state=IDLE, beat count=0, all accumulators=0.
  - Out_0..Out_9=0, out_valid=0, in_ready=0, busy=0.
  - Applies mid-inference too; the partial result is discarded.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - start=1 -> next state ACCUM; accumulators and count are cleared on that edge.
- ACCUM:
  - in_ready=1.
  - Each edge with in_valid&&in_ready: acc_k <= acc_k + sext(act*w_k) for k=0..9 (full-precision signed product, ACT_W+W_W bits, sign-extended to ACC_W); count++.
  - Gaps (in_valid=0) are allowed and hold state.
  - The edge accepting beat N_IN (count==N_IN-1) moves the FSM to DONE.
  - start=1 in ACCUM restarts the inference: accumulators and count are cleared and the state stays ACCUM. A beat presented in that same cycle is discarded.
- DONE (exactly one cycle):
  - in_ready=0; start and in_valid are ignored.
  - On the exit edge: Out_k <= sat(acc_k), out_valid <= 1, state -> IDLE.
- Latency: the last beat is accepted at edge E; Out_k and out_valid update at edge E+1. out_valid is high for exactly one cycle.
- Out_k hold their value until the next result load or reset.
- start is accepted in the cycle where out_valid=1, since the FSM is in IDLE then.
- Saturation, per class:
  - acc > 2^(OUT_W-1)-1 -> 26'h1FFFFFF.
  - acc < -2^(OUT_W-1) -> 26'h2000000.
  - Otherwise the low OUT_W bits of acc.
  - Bit 25 is the sign bit, consistent with the downstream comparator.
- Accumulators never wrap, guaranteed by the ACC_W constraint.
- busy=1 iff state is ACCUM or DONE.

Test Plan:
1. Reset: run 40 beats, then pulse GlobalReset=0 asynchronously (mid-cycle) -> Out_k=0, out_valid=0, in_ready=0, busy=0 immediately. A fresh start then gives results from new beats only.
2. Basic: start, then 100 back-to-back beats with act=1, w_k=k -> Out_k=100*k (Out_9=900). out_valid is one cycle, exactly one edge after the last accepted beat. in_ready=0 in DONE.
3. Sign/gaps: act=3, w_2=-5, in_valid toggling every other cycle for 100 beats -> Out_2=26'h3FFFA24 (-1500); out_valid only after the 100th accepted beat.
4. Saturation: act=32767, w_0=127, w_1=-128, other weights 0, 100 beats -> Out_0=26'h1FFFFFF, Out_1=26'h2000000, Out_2..Out_9=0.
5. Restart: 40 beats with act=5, w_0=1, then start with in_valid=1 in the same cycle, then 100 beats act=1, w_0=1 -> Out_0=100 (the restart-cycle beat and the first 40 beats are excluded).
6. Idle/overlap: in_valid=1 with act=7 in IDLE (no start) -> no accumulation. start asserted in the out_valid cycle -> busy=1 next cycle; the prior Out_k are held until the next result load.
